// File: rtl/icache_dm.sv
// Direct-mapped, blocking, read-only instruction cache between the fetch stage and the bridge read port.
// Cached misses refill a whole 16-byte line. Uncached fetches read a single word and do not allocate.
module icache_dm #(
  parameter int unsigned INDEX_W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_uncached,
  output logic         cpu_addr_ok,
  output logic         cpu_data_ok,
  output logic [31:0]  cpu_rdata,
  output logic         rd_req,
  output logic [2:0]   rd_type,
  output logic [31:0]  rd_addr,
  input  logic         rd_rdy,
  input  logic         ret_valid,
  input  logic [127:0] ret_data,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int unsigned TAG_W = 28 - INDEX_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_e;

  state_e             state_q;
  logic [31:0]        addr_q;
  logic               unc_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [31:0]        rdata_q;
  logic [31:0]        hit_cnt_q;
  logic [31:0]        miss_cnt_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag_buf;
  logic [1:0]         word;
  logic [127:0]       line_rd;
  logic               hit;
  logic               accept;
  logic               refill_done;
  logic               line_we;
  logic [31:0]        hit_word;
  logic [31:0]        ret_word;
  logic [31:0]        data_word;

  assign idx     = addr_q[INDEX_W+3:4];
  assign tag_buf = addr_q[31:INDEX_W+4];
  assign word    = addr_q[3:2];
  assign line_rd = data_q[idx];

  // Lookup is evaluated on the buffered request, one cycle after acceptance
  assign hit         = (state_q == LOOKUP) && !unc_q && valid_q[idx] && (tag_q[idx] == tag_buf);
  assign refill_done = (state_q == REFILL) && ret_valid;
  assign line_we     = refill_done && !unc_q && resetn;

  assign cpu_addr_ok = (state_q == IDLE) || hit;
  assign accept      = cpu_req && cpu_addr_ok;
  assign cpu_data_ok = hit || refill_done;

  assign hit_word  = line_rd[{word, 5'd0} +: 32];
  assign ret_word  = unc_q ? ret_data[31:0] : ret_data[{word, 5'd0} +: 32];
  assign data_word = hit ? hit_word : ret_word;
  assign cpu_rdata = cpu_data_ok ? data_word : rdata_q;

  // Bridge request is a pure function of the held request buffer, so it stays stable under backpressure
  assign rd_req  = (state_q == MISS);
  assign rd_type = unc_q ? 3'b010 : 3'b100;
  assign rd_addr = unc_q ? addr_q : {addr_q[31:4], 4'b0000};

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (cpu_data_ok) rdata_q <= data_word;
      case (state_q)
        IDLE: begin
          if (accept) state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            state_q   <= accept ? LOOKUP : IDLE;
          end else begin
            if (!unc_q) miss_cnt_q <= miss_cnt_q + 32'd1;
            state_q <= MISS;
          end
        end
        MISS: begin
          if (rd_rdy) state_q <= REFILL;
        end
        REFILL: begin
          if (ret_valid) begin
            if (!unc_q) valid_q[idx] <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request buffer and line storage carry no reset; validity alone qualifies them
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= cpu_addr;
      unc_q  <= cpu_uncached;
    end
    if (line_we) begin
      tag_q[idx]  <= tag_buf;
      data_q[idx] <= ret_data;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized fetches, checked against a
// residency model (index -> resident line address and contents) and an address-derived memory image.
module tb_icache_dm;

  localparam int unsigned LINES = 64;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_uncached;
  logic         cpu_addr_ok;
  logic         cpu_data_ok;
  logic [31:0]  cpu_rdata;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  icache_dm #(.INDEX_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_uncached(cpu_uncached),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which line address each index holds, its contents, and the counters
  logic [31:0]  res_line [int unsigned];
  logic [127:0] res_data [int unsigned];
  logic [31:0]  mdl_hit  = 0;
  logic [31:0]  mdl_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    if (la == 32'h1FC0_0000) return {32'h33, 32'h22, 32'h11, 32'h00};
    for (int k = 0; k < 4; k++) l[32*k +: 32] = ((la + 32'(k * 4)) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    return l;
  endfunction

  function automatic logic [31:0] unc_word(input logic [31:0] a);
    if (a == 32'hBFC0_0010) return 32'hDEAD_BEEF;
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // One complete fetch; the bench plays the bridge with the given accept and return delays
  task automatic fetch(input logic [31:0] a, input bit unc, input int rdy_dly, input int ret_dly);
    int unsigned  idx = (a >> 4) % LINES;
    logic [31:0]  la = a & ~32'hF;
    bit           exp_hit;
    logic [1:0]   w = a[3:2];
    logic [127:0] line;
    logic [31:0]  exp_word;
    logic [2:0]   exp_type = unc ? 3'b010 : 3'b100;
    logic [31:0]  exp_raddr = unc ? a : la;
    exp_hit = !unc && (res_line.exists(idx) != 0) && (res_line[idx] == la);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a; cpu_uncached = unc;
    #1;
    chk("addr_ok_idle", 32'(cpu_addr_ok), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_uncached = 1'($urandom);
    #1;
    if (exp_hit) begin
      line = res_data[idx];
      exp_word = 32'(line >> (32 * int'(w)));
      chk("hit_data_ok", 32'(cpu_data_ok), 32'd1);
      chk("hit_rdata", cpu_rdata, exp_word);
      chk("hit_no_rd_req", 32'(rd_req), 32'd0);
      mdl_hit++;
    end else begin
      chk("miss_data_ok", 32'(cpu_data_ok), 32'd0);
      chk("miss_addr_ok", 32'(cpu_addr_ok), 32'd0);
      if (!unc) mdl_miss++;
      for (int i = 0; i <= rdy_dly; i++) begin
        @(negedge clk); #1;
        chk("rd_req", 32'(rd_req), 32'd1);
        chk("rd_type", 32'(rd_type), 32'(exp_type));
        chk("rd_addr", rd_addr, exp_raddr);
        chk("miss_wait_addr_ok", 32'(cpu_addr_ok), 32'd0);
        rd_rdy = (i == rdy_dly);
      end
      @(negedge clk);
      rd_rdy = 1'b0;
      for (int j = 0; j < ret_dly; j++) begin
        #1;
        chk("refill_wait_data_ok", 32'(cpu_data_ok), 32'd0);
        chk("refill_wait_addr_ok", 32'(cpu_addr_ok), 32'd0);
        chk("refill_wait_rd_req", 32'(rd_req), 32'd0);
        @(negedge clk);
      end
      if (unc) begin
        exp_word = unc_word(a);
        line = {$urandom, $urandom, $urandom, exp_word};
      end else begin
        line = mem_line(la);
        exp_word = 32'(line >> (32 * int'(w)));
      end
      ret_valid = 1'b1; ret_data = line;
      #1;
      chk("refill_data_ok", 32'(cpu_data_ok), 32'd1);
      chk("refill_rdata", cpu_rdata, exp_word);
      chk("refill_addr_ok", 32'(cpu_addr_ok), 32'd0);
      if (!unc) begin
        res_line[idx] = la;
        res_data[idx] = line;
      end
    end
    @(negedge clk);
    ret_valid = 1'b0; ret_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("after_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("rdata_hold", cpu_rdata, exp_word);
    chk("hit_cnt", hit_cnt, mdl_hit);
    chk("miss_cnt", miss_cnt, mdl_miss);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    resetn = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_uncached = 1'b0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_addr_ok", 32'(cpu_addr_ok), 32'd1);
    chk("rst_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);

    // Cold miss with a five-cycle return
    fetch(32'h1FC0_0004, 1'b0, 0, 4);
    chk("cold_miss_cnt", miss_cnt, 32'd1);

    // Back-to-back hits on the freshly filled line
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h1FC0_0008; cpu_uncached = 1'b0;
    #1;
    chk("b2b_addr_ok0", 32'(cpu_addr_ok), 32'd1);
    @(negedge clk);
    cpu_addr = 32'h1FC0_000C;
    #1;
    chk("b2b_addr_ok1", 32'(cpu_addr_ok), 32'd1);
    chk("b2b_data_ok0", 32'(cpu_data_ok), 32'd1);
    chk("b2b_rdata0", cpu_rdata, 32'h22);
    chk("b2b_rd_req0", 32'(rd_req), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("b2b_data_ok1", 32'(cpu_data_ok), 32'd1);
    chk("b2b_rdata1", cpu_rdata, 32'h33);
    chk("b2b_rd_req1", 32'(rd_req), 32'd0);
    @(negedge clk); #1;
    chk("b2b_data_ok_end", 32'(cpu_data_ok), 32'd0);
    chk("b2b_hit_cnt", hit_cnt, 32'd2);
    mdl_hit = mdl_hit + 32'd2;

    // Conflict on index 0
    fetch(32'h1FC0_0000, 1'b0, 1, 2);
    fetch(32'h1FC0_0400, 1'b0, 0, 1);
    fetch(32'h1FC0_0000, 1'b0, 2, 0);
    chk("conflict_miss_cnt", miss_cnt, 32'd3);

    // Uncached fetches never allocate nor count as misses
    fetch(32'hBFC0_0010, 1'b1, 0, 2);
    fetch(32'hBFC0_0010, 1'b1, 1, 1);
    chk("unc_miss_cnt", miss_cnt, 32'd3);
    fetch(32'hBFC0_0010, 1'b0, 0, 1);
    chk("unc_then_cached_miss_cnt", miss_cnt, 32'd4);

    // Backpressure on the bridge request
    fetch(32'h0000_1234 & ~32'h3, 1'b0, 4, 2);

    // Randomized traffic concentrated on a few aliasing tags
    for (int n = 0; n < 200; n++) begin
      a = 32'h0040_0000 + 32'($urandom_range(0, 2)) * 32'h400
          + 32'($urandom_range(0, 7)) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
      fetch(a, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a refill is returning data
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h2000_0020; cpu_uncached = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    #1;
    chk("rr_refill_rd_req", 32'(rd_req), 32'd0);
    @(negedge clk);
    resetn = 1'b0; ret_valid = 1'b1; ret_data = mem_line(32'h2000_0020);
    @(negedge clk);
    resetn = 1'b1; ret_valid = 1'b0;
    #1;
    chk("rr_rd_req", 32'(rd_req), 32'd0);
    chk("rr_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("rr_addr_ok", 32'(cpu_addr_ok), 32'd1);
    chk("rr_rdata", cpu_rdata, 32'd0);
    chk("rr_hit_cnt", hit_cnt, 32'd0);
    chk("rr_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    ret_valid = 1'b1;
    #1;
    chk("rr_late_ret_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("rr_late_ret_addr_ok", 32'(cpu_addr_ok), 32'd1);
    @(negedge clk);
    ret_valid = 1'b0;
    res_line.delete(); res_data.delete();
    mdl_hit = 0; mdl_miss = 0;
    fetch(32'h2000_0020, 1'b0, 0, 1);
    fetch(32'h1FC0_0008, 1'b0, 0, 0);
    fetch(32'h1FC0_000C, 1'b0, 0, 0);
    chk("post_rst_hit_cnt", hit_cnt, 32'd1);
    chk("post_rst_miss_cnt", miss_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
